sort_pipe: RTL and testbench

Fully pipelined, parametrised bitonic sorting network with valid/ready flow control. It accepts one vector of SIZE keys per cycle and returns the vector sorted in ascending or descending order, selected per vector. Each key carries its original lane index, and ties are broken by that index, so the result is deterministic and stable. The block sits between a vector producer and consumer in the streaming datapath and replaces the single unregistered swap_by_order compare element as the team's general sorter.

---
 rtl/sort_pipe.sv | 123 ++++++++++++
 tb/tb_sort_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_pipe.sv
// Pipelined bitonic sorter: LOG_SIZE*(LOG_SIZE+1)/2 register stages, one compare-exchange level each.
// Global stall: every stage advances only when the output is empty or being taken (o_ready = ~o_valid | i_ready).
module sort_pipe #(
  parameter int DATA_W   = 8,
  parameter int LOG_SIZE = 4,
  parameter int SIZE     = 2**LOG_SIZE,
  parameter int SIGNED   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_desc,
  input  logic [DATA_W*SIZE-1:0]     i_din,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_desc,
  output logic [DATA_W*SIZE-1:0]     o_dout,
  output logic [LOG_SIZE*SIZE-1:0]   o_idx
);
  localparam int L  = LOG_SIZE*(LOG_SIZE+1)/2;
  localparam int KW = DATA_W*SIZE;
  localparam int IW = LOG_SIZE*SIZE;

  logic [L*KW-1:0] r_key;
  logic [L*IW-1:0] r_idx;
  logic [L-1:0]    r_desc;
  logic [L-1:0]    r_vld;

  logic [L*KW-1:0] w_kin;
  logic [L*IW-1:0] w_iin;
  logic [L*KW-1:0] w_knx;
  logic [L*IW-1:0] w_inx;
  logic [L-1:0]    w_dnx;
  logic [L-1:0]    w_vnx;
  logic [KW-1:0]   w_din_g;
  logic [IW-1:0]   w_idx_entry;
  logic            w_ce;
  logic            w_in_xfer;

  assign w_ce      = ~r_vld[L-1] | i_ready;
  assign o_ready   = w_ce;
  assign w_in_xfer = i_valid & w_ce;
  assign w_din_g   = w_in_xfer ? i_din : '0;

  // a precedes b in the order selected by desc; ties always resolve to the lower original lane
  function automatic logic prec(input logic [DATA_W-1:0] ka, input logic [LOG_SIZE-1:0] ia,
                                input logic [DATA_W-1:0] kb, input logic [LOG_SIZE-1:0] ib,
                                input logic desc);
    logic lt, gt;
    if (SIGNED != 0) begin
      lt = $signed(ka) < $signed(kb);
      gt = $signed(ka) > $signed(kb);
    end else begin
      lt = ka < kb;
      gt = ka > kb;
    end
    return (desc ? gt : lt) | ((ka == kb) & (ia < ib));
  endfunction

  for (genvar k = 0; k < SIZE; k++) begin : g_entry
    assign w_idx_entry[k*LOG_SIZE +: LOG_SIZE] = LOG_SIZE'(k);
  end

  for (genvar p = 0; p < LOG_SIZE; p++) begin : g_p
    for (genvar qq = 0; qq <= p; qq++) begin : g_q
      localparam int S = p*(p+1)/2 + qq;
      localparam int Q = p - qq;

      if (S == 0) begin : g_first
        assign w_kin[0 +: KW] = w_din_g;
        assign w_iin[0 +: IW] = w_idx_entry;
        assign w_dnx[0]       = w_in_xfer & i_desc;
        assign w_vnx[0]       = w_in_xfer;
      end else begin : g_next
        assign w_kin[S*KW +: KW] = r_key[(S-1)*KW +: KW];
        assign w_iin[S*IW +: IW] = r_idx[(S-1)*IW +: IW];
        assign w_dnx[S]          = r_desc[S-1];
        assign w_vnx[S]          = r_vld[S-1];
      end

      for (genvar j = 0; j < SIZE; j++) begin : g_j
        if (((j >> Q) & 1) == 0) begin : g_cmp
          localparam int PJ = j ^ (1 << Q);
          // lanes whose bit p+1 is set form the descending half of the next merge
          localparam bit RV = ((j >> (p+1)) & 1) != 0;
          logic [DATA_W-1:0]   w_kl, w_kh;
          logic [LOG_SIZE-1:0] w_il, w_ih;
          logic                w_swap;
          assign w_kl = w_kin[S*KW + j*DATA_W  +: DATA_W];
          assign w_kh = w_kin[S*KW + PJ*DATA_W +: DATA_W];
          assign w_il = w_iin[S*IW + j*LOG_SIZE  +: LOG_SIZE];
          assign w_ih = w_iin[S*IW + PJ*LOG_SIZE +: LOG_SIZE];
          assign w_swap = RV ? prec(w_kl, w_il, w_kh, w_ih, w_dnx[S])
                             : prec(w_kh, w_ih, w_kl, w_il, w_dnx[S]);
          assign w_knx[S*KW + j*DATA_W  +: DATA_W]   = w_swap ? w_kh : w_kl;
          assign w_knx[S*KW + PJ*DATA_W +: DATA_W]   = w_swap ? w_kl : w_kh;
          assign w_inx[S*IW + j*LOG_SIZE  +: LOG_SIZE] = w_swap ? w_ih : w_il;
          assign w_inx[S*IW + PJ*LOG_SIZE +: LOG_SIZE] = w_swap ? w_il : w_ih;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key  <= '0;
      r_idx  <= '0;
      r_desc <= '0;
      r_vld  <= '0;
    end else if (w_ce) begin
      r_key  <= w_knx;
      r_idx  <= w_inx;
      r_desc <= w_dnx;
      r_vld  <= w_vnx;
    end
  end

  assign o_valid = r_vld[L-1];
  assign o_desc  = r_desc[L-1];
  assign o_dout  = r_key[(L-1)*KW +: KW];
  assign o_idx   = r_idx[(L-1)*IW +: IW];
endmodule

// File: tb/tb_sort_pipe.sv
// Bench for sort_pipe: directed vector table, random streams with backpressure against a stable-sort model, reset and signed cases.
module tb_sort_pipe;
  localparam int DW = 8;
  localparam int LS = 4;
  localparam int N  = 16;
  localparam int L  = 10;
  localparam int KW = DW*N;
  localparam int IW = LS*N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_valid, o_ready, i_desc, o_valid, i_ready, o_desc;
  logic [KW-1:0] i_din, o_dout;
  logic [IW-1:0] o_idx;

  sort_pipe #(.DATA_W(DW), .LOG_SIZE(LS), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_desc(i_desc),
    .i_din(i_din), .o_valid(o_valid), .i_ready(i_ready), .o_desc(o_desc),
    .o_dout(o_dout), .o_idx(o_idx));

  logic        s_i_valid, s_o_ready, s_i_desc, s_o_valid, s_i_ready, s_o_desc;
  logic [31:0] s_i_din, s_o_dout;
  logic [7:0]  s_o_idx;

  sort_pipe #(.DATA_W(8), .LOG_SIZE(2), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .i_valid(s_i_valid), .o_ready(s_o_ready), .i_desc(s_i_desc),
    .i_din(s_i_din), .o_valid(s_o_valid), .i_ready(s_i_ready), .o_desc(s_o_desc),
    .o_dout(s_o_dout), .o_idx(s_o_idx));

  typedef struct {
    logic [KW-1:0] k;
    logic [IW-1:0] id;
    logic          d;
  } exp_t;

  typedef struct {
    logic [KW-1:0] din;
    logic          desc;
    logic [KW-1:0] ek;
    logic [IW-1:0] ei;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  vec_t tab[4];

  logic [KW-1:0] h_k;
  logic [IW-1:0] h_i;
  logic          h_d;
  bit            h_stall = 0;
  bit            last_acc;
  int            run = 0, max_run = 0, received = 0;

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Stable insertion sort: an element moves left only past keys that strictly follow it.
  function automatic exp_t ref_sort(input logic [KW-1:0] din, input logic d);
    int   key[N];
    int   ix[N];
    exp_t e;
    for (int i = 0; i < N; i++) begin
      key[i] = int'(din[i*DW +: DW]);
      ix[i]  = i;
    end
    for (int i = 1; i < N; i++) begin
      int k = key[i];
      int x = ix[i];
      int j = i - 1;
      while (j >= 0 && (d ? (k > key[j]) : (k < key[j]))) begin
        key[j+1] = key[j];
        ix[j+1]  = ix[j];
        j--;
      end
      key[j+1] = k;
      ix[j+1]  = x;
    end
    for (int i = 0; i < N; i++) begin
      e.k[i*DW +: DW] = DW'(key[i]);
      e.id[i*LS +: LS] = LS'(ix[i]);
    end
    e.d = d;
    return e;
  endfunction

  function automatic logic [KW-1:0] rand_vec();
    logic [KW-1:0] v;
    bit narrow = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < N; i++)
      v[i*DW +: DW] = narrow ? DW'($urandom_range(0, 5)) : DW'($urandom);
    return v;
  endfunction

  // One clock cycle: called just after an edge with inputs already driven.
  task automatic cycle();
    exp_t e;
    #1;
    chk("o_ready", {127'd0, o_ready}, {127'd0, !(o_valid && !i_ready)});
    if (h_stall) begin
      chk("hold_valid", {127'd0, o_valid}, 128'd1);
      chk("hold_dout", o_dout, h_k);
      chk("hold_idx", KW'(o_idx), KW'(h_i));
      chk("hold_desc", {127'd0, o_desc}, {127'd0, h_d});
    end
    run = o_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (o_valid && i_ready && !rst) begin
      received++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output got valid want none");
      end else begin
        e = q.pop_front();
        chk("sb_dout", o_dout, e.k);
        chk("sb_idx", KW'(o_idx), KW'(e.id));
        chk("sb_desc", {127'd0, o_desc}, {127'd0, e.d});
      end
    end
    last_acc = i_valid && o_ready && !rst;
    if (last_acc) q.push_back(ref_sort(i_din, i_desc));
    h_stall = o_valid && !i_ready && !rst;
    h_k = o_dout;
    h_i = o_idx;
    h_d = o_desc;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    i_valid = 1'b1;
    i_din   = v.din;
    i_desc  = v.desc;
    cycle();
    i_valid = 1'b0;
    i_din   = '0;
    lat = 1;
    while (!o_valid && lat < 40) begin
      cycle();
      lat++;
    end
    chk({tag, "_latency"}, KW'(lat), KW'(L));
    chk({tag, "_dout"}, o_dout, v.ek);
    chk({tag, "_idx"}, KW'(o_idx), KW'(v.ei));
    chk({tag, "_desc"}, {127'd0, o_desc}, {127'd0, v.desc});
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat, sent, budget;
    string tags[4];
    tags = '{"rev_asc", "tie_5a", "tie_37", "ramp_desc"};
    for (int k = 0; k < N; k++) begin
      tab[0].din[k*DW +: DW] = DW'(15 - k);
      tab[0].ek[k*DW +: DW]  = DW'(k);
      tab[0].ei[k*LS +: LS]  = LS'(15 - k);
      tab[1].din[k*DW +: DW] = 8'h5A;
      tab[1].ek[k*DW +: DW]  = 8'h5A;
      tab[1].ei[k*LS +: LS]  = LS'(k);
      tab[2].din[k*DW +: DW] = (k % 2 == 1) ? 8'd7 : 8'd3;
      tab[2].ek[k*DW +: DW]  = (k < 8) ? 8'd7 : 8'd3;
      tab[2].ei[k*LS +: LS]  = (k < 8) ? LS'(2*k + 1) : LS'(2*(k - 8));
      tab[3].din[k*DW +: DW] = DW'(3*k);
      tab[3].ek[k*DW +: DW]  = DW'(3*(15 - k));
      tab[3].ei[k*LS +: LS]  = LS'(15 - k);
    end
    tab[0].desc = 1'b0;
    tab[1].desc = 1'b1;
    tab[2].desc = 1'b1;
    tab[3].desc = 1'b1;

    rst = 1'b1; i_valid = 1'b0; i_desc = 1'b0; i_din = '0; i_ready = 1'b1;
    s_i_valid = 1'b0; s_i_desc = 1'b0; s_i_din = '0; s_i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_valid", {127'd0, o_valid}, 128'd0);
    chk("rst_dout", o_dout, '0);
    chk("rst_idx", KW'(o_idx), '0);
    chk("rst_desc", {127'd0, o_desc}, 128'd0);
    chk("rst_ready", {127'd0, o_ready}, 128'd1);
    @(posedge clk);
    #1;

    for (int t = 0; t < 4; t++) run_vec(tab[t], tags[t]);

    // back-to-back stream
    max_run = 0;
    for (int i = 0; i < 50; i++) begin
      i_valid = 1'b1;
      i_din   = rand_vec();
      i_desc  = i[0];
      cycle();
    end
    i_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    chk("stream_run", KW'(max_run), KW'(50));
    chk("stream_drained", KW'(q.size()), '0);

    // random backpressure, producer holds until accepted
    sent = 0; received = 0; budget = 0;
    while ((sent < 60 || q.size() > 0) && budget < 3000) begin
      i_ready = ($urandom_range(0, 99) >= 40);
      if (!i_valid && sent < 60 && $urandom_range(0, 4) != 0) begin
        i_valid = 1'b1;
        i_din   = rand_vec();
        i_desc  = 1'($urandom_range(0, 1));
      end
      cycle();
      if (last_acc) begin
        i_valid = 1'b0;
        sent++;
      end
      budget++;
    end
    i_ready = 1'b1;
    chk("bp_sent", KW'(sent), KW'(60));
    chk("bp_received", KW'(received), KW'(60));
    chk("bp_drained", KW'(q.size()), '0);
    cycle();

    // reset while vectors are in flight
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_din   = rand_vec();
      i_desc  = 1'b0;
      cycle();
    end
    i_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 10; i++) begin
      chk("rst_flush_valid", {127'd0, o_valid}, 128'd0);
      cycle();
    end
    run_vec(tab[0], "post_rst");

    // signed 4-lane instance
    s_i_valid = 1'b1;
    s_i_din   = {8'hFF, 8'h00, 8'h7F, 8'h80};
    @(posedge clk);
    #1 s_i_valid = 1'b0;
    lat = 1;
    while (!s_o_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("signed_latency", KW'(lat), KW'(3));
    chk("signed_dout", KW'(s_o_dout), KW'(32'h7F00FF80));
    chk("signed_idx", KW'(s_o_idx), KW'(8'h6C));
    chk("signed_desc", {127'd0, s_o_desc}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
